// File: rtl/unsigned_approx_mult_pipe.sv
// Two-stage unsigned multiplier with exact, truncated and truncated+compensated modes.
// Stage 1 reduces the column-masked partial products to sum/carry vectors; stage 2 adds them into z.
module unsigned_approx_mult_pipe #(
  parameter int W     = 8,
  parameter int LEVEL = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    z,
  output logic [15:0]       done_cnt
);

  localparam int PW = 2 * W;
  localparam logic [PW-1:0] ONE        = PW'(1);
  localparam logic [PW-1:0] TRUNC_MASK = ~((ONE << LEVEL) - ONE);
  localparam logic [PW-1:0] COMP_BIAS  = (ONE << LEVEL) >> 1;

  logic          en;
  logic [PW-1:0] xe;
  logic [PW-1:0] col_mask;
  logic [PW-1:0] pp;
  logic [PW-1:0] sum_c;
  logic [PW-1:0] carry_c;
  logic [PW-1:0] sum_nxt;

  logic [PW-1:0] sum_p1;
  logic [PW-1:0] carry_p1;
  logic          comp_p1;
  logic          vld_p1;

  // Final carry-propagate add plus the half-LSB bias that recentres the truncation error.
  function automatic logic [PW-1:0] final_add(input logic [PW-1:0] s,
                                              input logic [PW-1:0] c,
                                              input logic           comp);
    final_add = s + c + (comp ? COMP_BIAS : '0);
  endfunction

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign xe       = PW'(x);

  // Carry-save reduction of the masked rows; wrap above bit PW-1 is harmless because the true sum fits.
  always_comb begin
    col_mask = (mode == 2'd1 || mode == 2'd2) ? TRUNC_MASK : '1;
    sum_c    = '0;
    carry_c  = '0;
    pp       = '0;
    sum_nxt  = '0;
    for (int j = 0; j < W; j++) begin
      pp      = y[j] ? ((xe << j) & col_mask) : '0;
      sum_nxt = sum_c ^ carry_c ^ pp;
      carry_c = ((sum_c & carry_c) | (sum_c & pp) | (carry_c & pp)) << 1;
      sum_c   = sum_nxt;
    end
  end

  // Stage 1 boundary: sum/carry vectors and the latched compensation flag
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      sum_p1   <= sum_c;
      carry_p1 <= carry_c;
      comp_p1  <= (mode == 2'd2);
    end
  end

  // Stage 2 boundary: final add into z, valid tracking and consumed-result counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      z         <= '0;
      done_cnt  <= '0;
    end else begin
      if (en) begin
        vld_p1    <= in_valid;
        out_valid <= vld_p1;
        if (vld_p1) z <= final_add(sum_p1, carry_p1, comp_p1);
      end
      if (out_valid && out_ready) done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
// Scoreboard bench for unsigned_approx_mult_pipe (W=8, LEVEL=8): expected products are queued at
// acceptance from a bit-level reference model and compared in order as results are consumed.
module tb_unsigned_approx_mult_pipe;

  localparam int W     = 8;
  localparam int LEVEL = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   z;
  logic [15:0]      done_cnt;

  int checks;
  int failures;
  logic [2*W-1:0] exp_q[$];

  unsigned_approx_mult_pipe #(.W(W), .LEVEL(LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] m);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && (m == 2'd0 || m == 2'd3 || (i + j) >= LEVEL))
          acc = acc + (32'd1 << (i + j));
    if (m == 2'd2 && LEVEL > 0) acc = acc + (32'd1 << (LEVEL - 1));
    return acc[2*W-1:0];
  endfunction

  // One clock: sample handshakes 1ns after the inputs were set, push accepted work, end on the falling edge.
  task automatic tick(output logic acc, output logic fire, output logic [2*W-1:0] zo);
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    zo   = z;
    if (acc) exp_q.push_back(ref_mult(x, y, mode));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic acc, fire;
    logic [2*W-1:0] zo, e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; mode = 2'd0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0d exp=0", out_valid); end
    checks++; if (z !== '0) begin failures++; $display("FAIL rst_z got=%0d exp=0", z); end
    checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL rst_done_cnt got=%0d exp=0", done_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0d exp=1", in_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; x = 8'd13; y = 8'd11; mode = 2'd0; out_ready = 1'b1;
    tick(acc, fire, zo);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL first_accept got=%0d exp=1", acc); end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      tick(acc, fire, zo);
      if (fire) begin
        e = exp_q.pop_front();
        checks++; if (zo !== e) begin failures++; $display("FAIL first_result got=%0d exp=%0d", zo, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL first_timeout got=%0d exp=0 pending", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic acc, fire;
    logic [2*W-1:0] zo, e;
    logic [2*W-1:0] kexp [3];
    int idx;
    kexp[0] = 16'd65025; kexp[1] = 16'd63232; kexp[2] = 16'd63360;
    idx = 0;
    out_ready = 1'b1; x = 8'd255; y = 8'd255;
    for (int t = 0; t < 8; t++) begin
      in_valid = (t < 3);
      mode = (t < 3) ? 2'(t) : 2'd3;
      tick(acc, fire, zo);
      checks++; if (fire !== (t >= 2 && t <= 4)) begin failures++; $display("FAIL b2b_fire_t%0d got=%0d exp=%0d", t, fire, (t >= 2 && t <= 4)); end
      if (t == 0) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_early got=%0d exp=0", out_valid); end
      end
      if (t == 1) begin
        checks++; if (out_valid !== 1'b1 || z !== 16'd65025) begin failures++; $display("FAIL b2b_latency got=%0d/%0d exp=1/65025", out_valid, z); end
      end
      if (fire && idx < 3 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (zo !== kexp[idx]) begin failures++; $display("FAIL b2b_const%0d got=%0d exp=%0d", idx, zo, kexp[idx]); end
        checks++; if (zo !== e) begin failures++; $display("FAIL b2b_model%0d got=%0d exp=%0d", idx, zo, e); end
        idx++;
      end
    end
    checks++; if (idx != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", idx); end
  endtask

  task automatic test_small_operands();
    logic acc, fire;
    logic [2*W-1:0] zo, e;
    logic [W-1:0] xs [5];
    logic [1:0] ms [5];
    logic [2*W-1:0] kexp [5];
    int sent, got;
    xs[0] = 8'd1;  ms[0] = 2'd1; kexp[0] = 16'd0;
    xs[1] = 8'd1;  ms[1] = 2'd2; kexp[1] = 16'd128;
    xs[2] = 8'd16; ms[2] = 2'd0; kexp[2] = 16'd256;
    xs[3] = 8'd16; ms[3] = 2'd1; kexp[3] = 16'd256;
    xs[4] = 8'd16; ms[4] = 2'd2; kexp[4] = 16'd384;
    sent = 0; got = 0; out_ready = 1'b1;
    for (int t = 0; t < 20 && got < 5; t++) begin
      in_valid = (sent < 5);
      x = xs[(sent < 5) ? sent : 0]; y = x; mode = ms[(sent < 5) ? sent : 0];
      tick(acc, fire, zo);
      if (acc) sent++;
      if (fire) begin
        checks++;
        if (exp_q.size() == 0 || got >= 5) begin failures++; $display("FAIL small_extra got=%0d exp=none", zo); end
        else begin
          e = exp_q.pop_front();
          if (zo !== kexp[got] || zo !== e) begin failures++; $display("FAIL small%0d got=%0d exp=%0d", got, zo, kexp[got]); end
          got++;
        end
      end
    end
    checks++; if (got != 5) begin failures++; $display("FAIL small_count got=%0d exp=5", got); end
  endtask

  task automatic test_stall();
    logic acc, fire, have;
    logic [2*W-1:0] zo, e, zhold;
    logic [W-1:0] xs [3];
    logic [W-1:0] ys [3];
    logic [1:0] ms [3];
    int idx, got;
    xs[0] = 8'd3;  ys[0] = 8'd5;   ms[0] = 2'd0;
    xs[1] = 8'd200; ys[1] = 8'd9;  ms[1] = 2'd1;
    xs[2] = 8'd77; ys[2] = 8'd250; ms[2] = 2'd2;
    idx = 0; got = 0; have = 1'b0; zhold = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      x = xs[(idx < 3) ? idx : 0]; y = ys[(idx < 3) ? idx : 0]; mode = ms[(idx < 3) ? idx : 0];
      tick(acc, fire, zo);
      if (acc) idx++;
      if (out_valid && !have) begin
        have = 1'b1; zhold = z;
      end else if (have) begin
        checks++; if (z !== zhold) begin failures++; $display("FAIL stall_z_frozen got=%0d exp=%0d", z, zhold); end
      end
    end
    #1;
    checks++; if (idx != 2) begin failures++; $display("FAIL stall_buffered got=%0d exp=2", idx); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0d exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid got=%0d exp=1", out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 3 || exp_q.size() > 0); c++) begin
      in_valid = (idx < 3);
      x = xs[(idx < 3) ? idx : 0]; y = ys[(idx < 3) ? idx : 0]; mode = ms[(idx < 3) ? idx : 0];
      tick(acc, fire, zo);
      if (acc) idx++;
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stall_dup got=%0d exp=none", zo); end
        else begin
          e = exp_q.pop_front();
          if (zo !== e) begin failures++; $display("FAIL stall_order%0d got=%0d exp=%0d", got, zo, e); end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", got); end
  endtask

  task automatic test_reset_mid();
    logic acc, fire;
    logic [2*W-1:0] zo, e;
    out_ready = 1'b0; in_valid = 1'b1; x = 8'd99; y = 8'd123; mode = 2'd0;
    tick(acc, fire, zo);
    x = 8'd45; mode = 2'd1;
    tick(acc, fire, zo);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%0d exp=0", out_valid); end
    checks++; if (z !== '0) begin failures++; $display("FAIL mid_rst_z got=%0d exp=0", z); end
    checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_done_cnt got=%0d exp=0", done_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%0d exp=1", in_ready); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(acc, fire, zo);
      checks++; if (fire !== 1'b0) begin failures++; $display("FAIL mid_rst_stale got=%0d exp=none", zo); end
    end
    in_valid = 1'b1; x = 8'd7; y = 8'd6; mode = 2'd2;
    tick(acc, fire, zo);
    in_valid = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      tick(acc, fire, zo);
      if (fire) begin
        e = exp_q.pop_front();
        checks++; if (zo !== e) begin failures++; $display("FAIL mid_rst_after got=%0d exp=%0d", zo, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mid_rst_timeout got=%0d exp=0 pending", exp_q.size()); end
  endtask

  task automatic test_random();
    logic acc, fire;
    logic [2*W-1:0] zo, e;
    int sent, got;
    sent = 0; got = 0;
    for (int c = 0; c < 20000 && (sent < 2000 || exp_q.size() > 0); c++) begin
      in_valid  = (sent < 2000) && ($urandom_range(0, 3) != 0);
      x         = 8'($urandom);
      y         = 8'($urandom);
      mode      = 2'($urandom);
      out_ready = (sent >= 2000) || ($urandom_range(0, 2) != 0);
      tick(acc, fire, zo);
      if (acc) sent++;
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rand_extra got=%0d exp=none", zo); end
        else begin
          e = exp_q.pop_front();
          if (zo !== e) begin failures++; $display("FAIL rand%0d got=%0d exp=%0d", got, zo, e); end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 2000) begin failures++; $display("FAIL rand_count got=%0d exp=2000", got); end
  endtask

  task automatic test_wrap();
    logic acc, fire;
    logic [2*W-1:0] zo, e;
    int sent, got;
    apply_reset();
    sent = 0; got = 0; out_ready = 1'b1;
    for (int c = 0; c < 65600 && got < 65537; c++) begin
      in_valid = (sent < 65537);
      x = 8'(c); y = 8'(c >> 8); mode = 2'(c >> 3);
      tick(acc, fire, zo);
      if (acc) sent++;
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_extra got=%0d exp=none", zo); end
        else begin
          e = exp_q.pop_front();
          if (zo !== e) begin failures++; $display("FAIL wrap_data got=%0d exp=%0d", zo, e); end
        end
        got++;
        if (got == 65535) begin
          checks++; if (done_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%0d exp=65535", done_cnt); end
        end
        if (got == 65536) begin
          checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", done_cnt); end
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 65537) begin failures++; $display("FAIL wrap_count got=%0d exp=65537", got); end
    checks++; if (done_cnt !== 16'd1) begin failures++; $display("FAIL wrap_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_small_operands();
    test_stall();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
